// File: rtl/led_pkg.sv
// led_pkg: shared mode and direction encodings for the LED marquee.
package led_pkg;

  // Per-channel animation mode, as driven on mode_a / mode_b.
  typedef enum logic [1:0] {
    MODE_HOLD   = 2'd0,
    MODE_ROR    = 2'd1,
    MODE_ROL    = 2'd2,
    MODE_BOUNCE = 2'd3
  } mode_e;

  // Travel direction of a bouncing channel.
  typedef enum logic {
    DIR_RIGHT = 1'b0,
    DIR_LEFT  = 1'b1
  } dir_e;

endpackage : led_pkg

// File: rtl/led_tick_gen.sv
// led_tick_gen: free-running DIV-bit counter with a one-cycle tick while the
// counter sits at all-ones. The tick is registered one count early so that it
// lines up exactly with the all-ones counter value.
module led_tick_gen #(
  parameter int unsigned DIV = 1
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam logic [DIV-1:0] CNT_LAST = '1;
  localparam logic [DIV-1:0] CNT_PRE  = CNT_LAST - DIV'(1);

  logic [DIV-1:0] cnt_q;
  logic [DIV-1:0] cnt_d;
  logic           tick_q;
  logic           tick_d;

  // Next count wraps naturally; tick goes high as the counter enters all-ones.
  always_comb begin
    cnt_d  = cnt_q + DIV'(1);
    tick_d = (cnt_q == CNT_PRE);
  end

  // Counter and tick registers; reset discards any pending tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule : led_tick_gen

// File: rtl/led_marquee.sv
// led_marquee: two independently animated LED patterns OR-ed onto one bar.
// Channel A/B each pick the fast or slow tick (swapped by speed) and rotate,
// hold or (with LED_MARQUEE_BOUNCE_EN defined) bounce between the ends.
// Without LED_MARQUEE_BOUNCE_EN, mode 3 acts as HOLD and no direction state exists.
module led_marquee
  import led_pkg::*;
#(
  parameter int unsigned       WIDTH    = 16,
  parameter int unsigned       FAST_DIV = 23,
  parameter int unsigned       SLOW_DIV = 25,
  parameter logic [WIDTH-1:0]  INIT_A   = WIDTH'(32'h0000_8000),
  parameter logic [WIDTH-1:0]  INIT_B   = WIDTH'(32'h0000_0007)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             speed,
  input  logic [1:0]       mode_a,
  input  logic [1:0]       mode_b,
  input  logic             load,
  output logic [WIDTH-1:0] led,
  output logic             tick_fast,
  output logic             tick_slow
);

  logic [WIDTH-1:0] pat_a_q, pat_a_d;
  logic [WIDTH-1:0] pat_b_q, pat_b_d;
  logic [WIDTH-1:0] led_q;
  logic             tick_a;
  logic             tick_b;
  mode_e            mode_a_e;
  mode_e            mode_b_e;
`ifdef LED_MARQUEE_BOUNCE_EN
  dir_e             dir_a_q, dir_a_d;
  dir_e             dir_b_q, dir_b_d;
`endif

  led_tick_gen #(.DIV(FAST_DIV)) u_tick_fast (
    .clk  (clk),
    .rst  (rst),
    .tick (tick_fast)
  );

  led_tick_gen #(.DIV(SLOW_DIV)) u_tick_slow (
    .clk  (clk),
    .rst  (rst),
    .tick (tick_slow)
  );

  // One rotation step; HOLD and any unsupported mode leave the pattern alone.
  function automatic logic [WIDTH-1:0] rotate_step(input logic [WIDTH-1:0] pat,
                                                   input mode_e            mode);
    rotate_step = pat;
    case (mode)
      MODE_ROR: rotate_step = {pat[0], pat[WIDTH-1:1]};
      MODE_ROL: rotate_step = {pat[WIDTH-2:0], pat[WIDTH-1]};
      default:  rotate_step = pat;
    endcase
  endfunction

`ifdef LED_MARQUEE_BOUNCE_EN
  // One bounce step: flip at the end being pushed against, then shift the new way.
  // Empty and full bars are frozen so they never lose or gain lit bits.
  function automatic void bounce_step(input  logic [WIDTH-1:0] pat,
                                      input  dir_e             dir,
                                      output logic [WIDTH-1:0] pat_n,
                                      output dir_e             dir_n);
    dir_n = dir;
    pat_n = pat;
    if ((pat != '0) && (pat != '1)) begin
      if ((dir == DIR_RIGHT) && pat[0]) begin
        dir_n = DIR_LEFT;
      end else if ((dir == DIR_LEFT) && pat[WIDTH-1]) begin
        dir_n = DIR_RIGHT;
      end
      pat_n = (dir_n == DIR_RIGHT) ? (pat >> 1) : (pat << 1);
    end
  endfunction
`endif

  assign mode_a_e = mode_e'(mode_a);
  assign mode_b_e = mode_e'(mode_b);
  assign tick_a   = speed ? tick_slow : tick_fast;
  assign tick_b   = speed ? tick_fast : tick_slow;

  // Next pattern per channel: load beats an enabled tick, otherwise hold.
  always_comb begin
    pat_a_d = pat_a_q;
    pat_b_d = pat_b_q;
`ifdef LED_MARQUEE_BOUNCE_EN
    dir_a_d = dir_a_q;
    dir_b_d = dir_b_q;
`endif
    if (load) begin
      pat_a_d = INIT_A;
      pat_b_d = INIT_B;
`ifdef LED_MARQUEE_BOUNCE_EN
      dir_a_d = DIR_RIGHT;
      dir_b_d = DIR_LEFT;
`endif
    end else begin
      if (en && tick_a) begin
`ifdef LED_MARQUEE_BOUNCE_EN
        if (mode_a_e == MODE_BOUNCE) bounce_step(pat_a_q, dir_a_q, pat_a_d, dir_a_d);
        else                         pat_a_d = rotate_step(pat_a_q, mode_a_e);
`else
        pat_a_d = rotate_step(pat_a_q, mode_a_e);
`endif
      end
      if (en && tick_b) begin
`ifdef LED_MARQUEE_BOUNCE_EN
        if (mode_b_e == MODE_BOUNCE) bounce_step(pat_b_q, dir_b_q, pat_b_d, dir_b_d);
        else                         pat_b_d = rotate_step(pat_b_q, mode_b_e);
`else
        pat_b_d = rotate_step(pat_b_q, mode_b_e);
`endif
      end
    end
  end

  // Pattern, direction and LED registers; led tracks the patterns in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pat_a_q <= INIT_A;
      pat_b_q <= INIT_B;
      led_q   <= INIT_A | INIT_B;
`ifdef LED_MARQUEE_BOUNCE_EN
      dir_a_q <= DIR_RIGHT;
      dir_b_q <= DIR_LEFT;
`endif
    end else begin
      pat_a_q <= pat_a_d;
      pat_b_q <= pat_b_d;
      led_q   <= pat_a_d | pat_b_d;
`ifdef LED_MARQUEE_BOUNCE_EN
      dir_a_q <= dir_a_d;
      dir_b_q <= dir_b_d;
`endif
    end
  end

  assign led = led_q;

endmodule : led_marquee

// File: tb/tb_led_marquee.sv
// tb_led_marquee: directed checks of the LED marquee at WIDTH=16, FAST_DIV=2,
// SLOW_DIV=4. Cycle 0 is the falling edge at which reset is released; outputs
// are sampled on falling edges, inputs change on falling edges.
module tb_led_marquee;

  logic        clk;
  logic        rst;
  logic        en;
  logic        speed;
  logic [1:0]  mode_a;
  logic [1:0]  mode_b;
  logic        load;
  logic [15:0] led;
  logic        tick_fast;
  logic        tick_slow;

  int n_cmp;
  int n_bad;
  int cyc;

  led_marquee #(
    .WIDTH    (16),
    .FAST_DIV (2),
    .SLOW_DIV (4),
    .INIT_A   (16'h8000),
    .INIT_B   (16'h0007)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .speed     (speed),
    .mode_a    (mode_a),
    .mode_b    (mode_b),
    .load      (load),
    .led       (led),
    .tick_fast (tick_fast),
    .tick_slow (tick_slow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; sampling point is the following falling edge.
  task automatic step();
    @(negedge clk);
    cyc++;
  endtask

  // Reset with the given configuration, then release at a falling edge (cycle 0).
  task automatic do_reset(input logic [1:0] ma, input logic [1:0] mb,
                          input logic spd, input logic e);
    rst    = 1'b1;
    mode_a = ma;
    mode_b = mb;
    speed  = spd;
    en     = e;
    load   = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    en = 1'b1; speed = 1'b0; mode_a = 2'd1; mode_b = 2'd1; load = 1'b0;
    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (led !== 16'h8007) begin
      n_bad++; $display("FAIL reset_led: got %h expected %h", led, 16'h8007);
    end
    n_cmp++;
    if (tick_fast !== 1'b0 || tick_slow !== 1'b0) begin
      n_bad++; $display("FAIL reset_ticks: got fast=%b slow=%b expected 0 0", tick_fast, tick_slow);
    end
  endtask

  // Both channels ROR, speed 0: A every 4 cycles, B every 16.
  task automatic test_ror();
    logic [15:0] exp_led;
    do_reset(2'd1, 2'd1, 1'b0, 1'b1);
    for (int c = 0; c <= 16; c++) begin
      if      (c < 4)  exp_led = 16'h8007;
      else if (c < 8)  exp_led = 16'h4007;
      else if (c < 12) exp_led = 16'h2007;
      else if (c < 16) exp_led = 16'h1007;
      else             exp_led = 16'h8803;
      n_cmp++;
      if (led !== exp_led) begin
        n_bad++; $display("FAIL ror_led cyc %0d: got %h expected %h", cyc, led, exp_led);
      end
      n_cmp++;
      if (tick_fast !== ((c % 4) == 3)) begin
        n_bad++; $display("FAIL ror_tick_fast cyc %0d: got %b expected %b", cyc, tick_fast, ((c % 4) == 3));
      end
      n_cmp++;
      if (tick_slow !== ((c % 16) == 15)) begin
        n_bad++; $display("FAIL ror_tick_slow cyc %0d: got %b expected %b", cyc, tick_slow, ((c % 16) == 15));
      end
      step();
    end
  endtask

  // speed=1: A (ROL) on slow tick wraps 8000->0001, B (ROR) on fast tick.
  task automatic test_speed();
    logic [15:0] exp_led;
    do_reset(2'd2, 2'd1, 1'b1, 1'b1);
    for (int c = 0; c <= 16; c++) begin
      if      (c < 4)  exp_led = 16'h8007;
      else if (c < 8)  exp_led = 16'h8003;
      else if (c < 12) exp_led = 16'hC001;
      else if (c < 16) exp_led = 16'hE000;
      else             exp_led = 16'h7001;
      n_cmp++;
      if (led !== exp_led) begin
        n_bad++; $display("FAIL speed_led cyc %0d: got %h expected %h", cyc, led, exp_led);
      end
      step();
    end
  endtask

  // en=0 freezes led while ticks keep running; enabling shifts once at next tick.
  task automatic test_enable();
    int pulses;
    int frozen_bad;
    do_reset(2'd1, 2'd1, 1'b0, 1'b0);
    pulses = 0;
    frozen_bad = 0;
    for (int c = 0; c < 40; c++) begin
      if (tick_fast === 1'b1) pulses++;
      if (led !== 16'h8007) frozen_bad++;
      step();
    end
    n_cmp++;
    if (frozen_bad !== 0) begin
      n_bad++; $display("FAIL enable_frozen: got %0d changed cycles expected 0", frozen_bad);
    end
    n_cmp++;
    if (pulses !== 10) begin
      n_bad++; $display("FAIL enable_ticks: got %0d fast pulses expected 10", pulses);
    end
    en = 1'b1;
    repeat (3) step();
    n_cmp++;
    if (led !== 16'h8007) begin
      n_bad++; $display("FAIL enable_pre cyc %0d: got %h expected %h", cyc, led, 16'h8007);
    end
    step();
    n_cmp++;
    if (led !== 16'h4007) begin
      n_bad++; $display("FAIL enable_shift cyc %0d: got %h expected %h", cyc, led, 16'h4007);
    end
  endtask

  // load coincident with a tick reloads INIT values and suppresses the shift.
  task automatic test_load();
    do_reset(2'd1, 2'd1, 1'b0, 1'b1);
    repeat (11) step();
    n_cmp++;
    if (led !== 16'h2007 || tick_fast !== 1'b1) begin
      n_bad++; $display("FAIL load_pre cyc %0d: got %h/%b expected %h/1", cyc, led, tick_fast, 16'h2007);
    end
    load = 1'b1;
    step();
    load = 1'b0;
    n_cmp++;
    if (led !== 16'h8007) begin
      n_bad++; $display("FAIL load_reload cyc %0d: got %h expected %h", cyc, led, 16'h8007);
    end
    repeat (4) step();
    n_cmp++;
    if (led !== 16'hC003) begin
      n_bad++; $display("FAIL load_after cyc %0d: got %h expected %h", cyc, led, 16'hC003);
    end
  endtask

  // Async reset mid-run clears a live tick; first tick after release is 4 cycles on.
  task automatic test_reset_midrun();
    do_reset(2'd1, 2'd1, 1'b0, 1'b1);
    repeat (7) step();
    rst = 1'b1;
    #1;
    n_cmp++;
    if (tick_fast !== 1'b0 || led !== 16'h8007) begin
      n_bad++; $display("FAIL midrst_async: got %h/%b expected %h/0", led, tick_fast, 16'h8007);
    end
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
    repeat (2) step();
    n_cmp++;
    if (tick_fast !== 1'b0) begin
      n_bad++; $display("FAIL midrst_early_tick cyc %0d: got %b expected 0", cyc, tick_fast);
    end
    step();
    n_cmp++;
    if (tick_fast !== 1'b1 || led !== 16'h8007) begin
      n_bad++; $display("FAIL midrst_tick cyc %0d: got %h/%b expected %h/1", cyc, led, tick_fast, 16'h8007);
    end
    step();
    n_cmp++;
    if (led !== 16'h4007) begin
      n_bad++; $display("FAIL midrst_shift cyc %0d: got %h expected %h", cyc, led, 16'h4007);
    end
  endtask

  // A in mode 3 on fast tick, B ROL on slow tick so A's low bits stay visible.
  task automatic test_bounce();
    logic [15:0] exp_led;
    do_reset(2'd3, 2'd2, 1'b0, 1'b1);
    for (int c = 0; c <= 124; c++) begin
      if (c == 4 || c == 60 || c == 64 || c == 68 || c == 120 || c == 124) begin
`ifdef LED_MARQUEE_BOUNCE_EN
        case (c)
          4:       exp_led = 16'h4007;
          60:      exp_led = 16'h0039;
          64:      exp_led = 16'h0072;
          68:      exp_led = 16'h0074;
          120:     exp_led = 16'h8380;
          default: exp_led = 16'h4380;
        endcase
`else
        case (c)
          4:       exp_led = 16'h8007;
          60:      exp_led = 16'h8038;
          64:      exp_led = 16'h8070;
          68:      exp_led = 16'h8070;
          default: exp_led = 16'h8380;
        endcase
`endif
        n_cmp++;
        if (led !== exp_led) begin
          n_bad++; $display("FAIL bounce_led cyc %0d: got %h expected %h", cyc, led, exp_led);
        end
      end
      step();
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    cyc   = 0;
    test_reset();
    test_ror();
    test_speed();
    test_enable();
    test_load();
    test_reset_midrun();
    test_bounce();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_led_marquee
